// File: rtl/keypad_code_entry_if.sv
// Keypad-side and controller-side signals of the PIN entry block, bundled for port connection.
interface keypad_code_entry_if;
    logic       key_valid;
    logic [3:0] key_val;
    logic       active_in;
    logic [5:0] code_out;
    logic       entry_busy;
    logic       locked;
    logic       fail_pulse;
    logic [2:0] fail_cnt;

    modport master (
        output key_valid, key_val, active_in,
        input  code_out, entry_busy, locked, fail_pulse, fail_cnt
    );

    modport slave (
        input  key_valid, key_val, active_in,
        output code_out, entry_busy, locked, fail_pulse, fail_cnt
    );
endinterface

// File: rtl/keypad_code_entry.sv
// Collects keypad digits, checks them against a fixed PIN and issues the arm/disarm
// command word to the alarm controller; repeated failures lock the keypad out.
module keypad_code_entry #(
    parameter int          PIN_LEN     = 4,
    parameter logic [31:0] PIN         = 32'h0000_1234,
    parameter int          TIMEOUT_CYC = 5000,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCKOUT_CYC = 20000,
    parameter int          ISSUE_CYC   = 2,
    parameter logic [5:0]  CODE_ARM    = 6'b011111,
    parameter logic [5:0]  CODE_DISARM = 6'b000100,
    parameter logic [5:0]  CODE_IDLE   = 6'b000000
) (
    input logic                clk,
    input logic                rst_n,
    keypad_code_entry_if.slave bus
);

    function automatic logic [31:0] nibble_mask(input int n);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                m[4*i +: 4] = 4'hF;
            end else begin
                m[4*i +: 4] = 4'h0;
            end
        end
        return m;
    endfunction

    localparam int TMAX_A = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
    localparam int TMAX   = (TMAX_A > ISSUE_CYC) ? TMAX_A : ISSUE_CYC;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] LK_LAST    = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] IS_LAST    = TW'(ISSUE_CYC - 1);
    localparam logic [3:0]    PIN_LEN_C  = 4'(PIN_LEN);
    localparam logic [2:0]    MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [31:0]   PIN_MASK   = nibble_mask(PIN_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_buf;
    logic [3:0]    r_cnt;
    logic          r_ovf;
    logic [TW-1:0] r_tmr;
    logic [2:0]    r_fail_cnt;
    logic [5:0]    r_code_out;
    logic          r_entry_busy;
    logic          r_locked;
    logic          r_fail_pulse;

    logic          w_digit;
    logic          w_clear;
    logic          w_enter;
    logic          w_key_acc;
    logic          w_match;
    logic [2:0]    w_fail_inc;

    assign w_digit    = bus.key_valid && (bus.key_val <= 4'd9);
    assign w_clear    = bus.key_valid && (bus.key_val == 4'hA);
    assign w_enter    = bus.key_valid && (bus.key_val == 4'hB);
    assign w_key_acc  = (r_state == ST_ENTRY) && (w_digit || w_clear || w_enter);
    assign w_match    = (r_cnt == PIN_LEN_C) && !r_ovf && ((r_buf & PIN_MASK) == (PIN & PIN_MASK));
    assign w_fail_inc = r_fail_cnt + 3'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_digit) w_next = ST_ENTRY;
                else         w_next = ST_IDLE;
            end
            ST_ENTRY: begin
                if (w_enter)                  w_next = ST_CHECK;
                else if (w_digit || w_clear)  w_next = ST_ENTRY;
                else if (r_tmr == TO_LAST)    w_next = ST_IDLE;
                else                          w_next = ST_ENTRY;
            end
            ST_CHECK: begin
                if (w_match)                       w_next = ST_ISSUE;
                else if (w_fail_inc == MAX_FAIL_C) w_next = ST_LOCKOUT;
                else                               w_next = ST_IDLE;
            end
            ST_ISSUE: begin
                if (r_tmr == IS_LAST) w_next = ST_IDLE;
                else                  w_next = ST_ISSUE;
            end
            ST_LOCKOUT: begin
                if (r_tmr == LK_LAST) w_next = ST_IDLE;
                else                  w_next = ST_LOCKOUT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shared timer: restarts on every state change and on every accepted key in ENTRY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= {TW{1'b0}};
        end else if ((r_state == ST_IDLE) || (w_next != r_state) || w_key_acc) begin
            r_tmr <= {TW{1'b0}};
        end else begin
            r_tmr <= r_tmr + TW'(1);
        end
    end

    // Digit buffer, digit count and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= 32'h0000_0000;
            r_cnt <= 4'd0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_digit) begin
                        r_buf <= {28'h000_0000, bus.key_val};
                        r_cnt <= 4'd1;
                        r_ovf <= 1'b0;
                    end
                end
                ST_ENTRY: begin
                    if (w_digit) begin
                        r_buf <= {r_buf[27:0], bus.key_val};
                        if (r_cnt == PIN_LEN_C) r_ovf <= 1'b1;
                        else                    r_cnt <= r_cnt + 4'd1;
                    end else if (w_clear || (w_next == ST_IDLE)) begin
                        r_buf <= 32'h0000_0000;
                        r_cnt <= 4'd0;
                        r_ovf <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_buf <= 32'h0000_0000;
                    r_cnt <= 4'd0;
                    r_ovf <= 1'b0;
                end
                default: begin
                    r_buf <= r_buf;
                end
            endcase
        end
    end

    // Consecutive failure counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= 3'd0;
        end else if (r_state == ST_CHECK) begin
            r_fail_cnt <= w_match ? 3'd0 : w_fail_inc;
        end else if ((r_state == ST_LOCKOUT) && (w_next == ST_IDLE)) begin
            r_fail_cnt <= 3'd0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_out   <= CODE_IDLE;
            r_entry_busy <= 1'b0;
            r_locked     <= 1'b0;
            r_fail_pulse <= 1'b0;
        end else begin
            if (w_next == ST_ISSUE) begin
                r_code_out <= (r_state == ST_CHECK) ? (bus.active_in ? CODE_DISARM : CODE_ARM)
                                                    : r_code_out;
            end else begin
                r_code_out <= CODE_IDLE;
            end
            r_entry_busy <= (w_next == ST_ENTRY) || (w_next == ST_CHECK) || (w_next == ST_ISSUE);
            r_locked     <= (w_next == ST_LOCKOUT);
            r_fail_pulse <= (w_next == ST_CHECK) && !w_match;
        end
    end

    assign bus.code_out   = r_code_out;
    assign bus.entry_busy = r_entry_busy;
    assign bus.locked     = r_locked;
    assign bus.fail_pulse = r_fail_pulse;
    assign bus.fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Randomised bench for keypad_code_entry with a digit-queue reference model of PIN attempts.
module tb_keypad_code_entry;

    localparam int          PIN_LEN     = 4;
    localparam logic [31:0] PIN         = 32'h0000_1234;
    localparam int          TIMEOUT_CYC = 5000;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCKOUT_CYC = 20000;
    localparam int          ISSUE_CYC   = 2;
    localparam logic [5:0]  CODE_ARM    = 6'b011111;
    localparam logic [5:0]  CODE_DISARM = 6'b000100;
    localparam logic [5:0]  CODE_IDLE   = 6'b000000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    keypad_code_entry_if kif();

    keypad_code_entry #(
        .PIN_LEN(PIN_LEN), .PIN(PIN), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYC(LOCKOUT_CYC), .ISSUE_CYC(ISSUE_CYC), .CODE_ARM(CODE_ARM),
        .CODE_DISARM(CODE_DISARM), .CODE_IDLE(CODE_IDLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(kif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_lock = 0;
    int m_fail = 0;
    int exp_pin[PIN_LEN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_val   = k;
        @(negedge clk);
        kif.key_valid = 1'b0;
        kif.key_val   = 4'h0;
    endtask

    // Presses the keys then enter; the model decides the outcome from the queue of digits entered
    task automatic run_attempt(input string tag, input logic [3:0] keys[$], input logic act);
        int         q[$];
        bit         match;
        bit         lock_exp;
        logic [5:0] word;
        kif.active_in = act;
        foreach (keys[i]) begin
            if (keys[i] <= 4'd9)       q.push_back(int'(keys[i]));
            else if (keys[i] == 4'hA)  q.delete();
            press(keys[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        match = (q.size() == PIN_LEN);
        if (match) begin
            for (int i = 0; i < PIN_LEN; i++) begin
                if (q[i] != exp_pin[i]) match = 1'b0;
            end
        end
        if (match) m_fail = 0;
        else       m_fail++;
        lock_exp = !match && (m_fail == MAX_FAIL);
        word     = match ? (act ? CODE_DISARM : CODE_ARM) : CODE_IDLE;
        press(4'hB);
        check({tag, "/check_busy"}, 32'(kif.entry_busy), 32'(1'b1));
        check({tag, "/fail_pulse"}, 32'(kif.fail_pulse), 32'(!match));
        check({tag, "/code_in_check"}, 32'(kif.code_out), 32'(CODE_IDLE));
        for (int c = 0; c < ISSUE_CYC; c++) begin
            @(negedge clk);
            if (c == 0) begin
                t_lock = cyc;
                check({tag, "/fail_cnt"}, 32'(kif.fail_cnt), 32'(m_fail));
                check({tag, "/locked"}, 32'(kif.locked), 32'(lock_exp));
                check({tag, "/pulse_end"}, 32'(kif.fail_pulse), 32'(1'b0));
                kif.active_in = ~act;
            end
            check($sformatf("%s/code%0d", tag, c), 32'(kif.code_out), 32'(word));
        end
        @(negedge clk);
        check({tag, "/code_end"}, 32'(kif.code_out), 32'(CODE_IDLE));
        check({tag, "/busy_end"}, 32'(kif.entry_busy), 32'(1'b0));
    endtask

    initial begin
        logic [31:0] pin_v;
        logic [3:0]  ks[$];
        int          t0;
        int          guard;
        int          kind;

        pin_v = PIN;
        for (int i = 0; i < PIN_LEN; i++) exp_pin[i] = int'(pin_v[4*(PIN_LEN-1-i) +: 4]);

        rst_n = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_val   = 4'h0;
        kif.active_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/code_out", 32'(kif.code_out), 32'(CODE_IDLE));
        check("rst/busy", 32'(kif.entry_busy), 32'(1'b0));
        check("rst/locked", 32'(kif.locked), 32'(1'b0));
        check("rst/pulse", 32'(kif.fail_pulse), 32'(1'b0));
        check("rst/fail_cnt", 32'(kif.fail_cnt), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        ks = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_attempt("arm", ks, 1'b0);
        run_attempt("disarm", ks, 1'b1);
        ks = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        run_attempt("overflow", ks, 1'b0);
        ks = '{4'h9, 4'h9, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4};
        run_attempt("clear_then_pin", ks, 1'b0);
        ks = '{4'h5, 4'h5};
        run_attempt("short_wrong", ks, 1'b1);

        // Abandoned entry after the idle timeout keeps the failure count
        press(4'h1);
        check("tmo/busy", 32'(kif.entry_busy), 32'(1'b1));
        t0 = cyc;
        guard = 0;
        while (kif.entry_busy && guard < TIMEOUT_CYC + 100) begin
            @(negedge clk);
            guard++;
        end
        check("tmo/length", 32'(cyc - t0), 32'(TIMEOUT_CYC));
        check("tmo/fail_cnt", 32'(kif.fail_cnt), 32'(m_fail));
        ks = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_attempt("after_tmo", ks, 1'b1);

        ks = '{4'h7};
        run_attempt("bad1", ks, 1'b0);
        ks = '{4'h1, 4'h2, 4'h3};
        run_attempt("bad2", ks, 1'b0);
        ks = '{4'h4, 4'h3, 4'h2, 4'h1};
        run_attempt("bad3", ks, 1'b0);
        foreach (exp_pin[i]) press(4'(exp_pin[i]));
        press(4'hB);
        repeat (3) begin
            @(negedge clk);
            check("lock/code_out", 32'(kif.code_out), 32'(CODE_IDLE));
        end
        check("lock/locked", 32'(kif.locked), 32'(1'b1));
        check("lock/busy", 32'(kif.entry_busy), 32'(1'b0));
        check("lock/fail_cnt", 32'(kif.fail_cnt), 32'(MAX_FAIL));
        guard = 0;
        while (kif.locked && guard < LOCKOUT_CYC + 100) begin
            @(negedge clk);
            guard++;
        end
        check("lock/length", 32'(cyc - t_lock), 32'(LOCKOUT_CYC));
        check("lock/fail_cnt_clr", 32'(kif.fail_cnt), 32'(0));
        m_fail = 0;

        for (int a = 0; a < 24; a++) begin
            ks.delete();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) ks.push_back(4'($urandom_range(0, 9)));
                ks.push_back(4'hA);
            end
            kind = (m_fail == MAX_FAIL - 1) ? 0 : int'($urandom_range(0, 2));
            if (kind == 1) begin
                repeat ($urandom_range(1, 6)) ks.push_back(4'($urandom_range(0, 9)));
            end else begin
                foreach (exp_pin[i]) ks.push_back(4'(exp_pin[i]));
                if (kind == 2) ks.push_back(4'($urandom_range(0, 9)));
            end
            if ($urandom_range(0, 1) == 1) ks.insert($urandom_range(0, ks.size() - 1), 4'($urandom_range(12, 15)));
            run_attempt($sformatf("rnd%0d", a), ks, 1'($urandom_range(0, 1)));
        end

        // Reset while the command word is being issued
        kif.active_in = 1'b0;
        foreach (exp_pin[i]) press(4'(exp_pin[i]));
        press(4'hB);
        @(negedge clk);
        check("rst_issue/code_before", 32'(kif.code_out), 32'(CODE_ARM));
        #1 rst_n = 1'b0;
        #1;
        check("rst_issue/code_now", 32'(kif.code_out), 32'(CODE_IDLE));
        check("rst_issue/busy_now", 32'(kif.entry_busy), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_issue/code_after", 32'(kif.code_out), 32'(CODE_IDLE));
        check("rst_issue/fail_cnt", 32'(kif.fail_cnt), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
